n2_lsu_pq: RTL and testbench
============================

N2_LSU_PQ -- requirements
Module: n2_lsu_pq

Interface
REQ-001 Parameter DEPTH, 8, LSQ entries; power of 2, >=2.
REQ-002 Parameter RIDX_W, 5, register-index width.
REQ-003 Parameter UID_W, 8, instruction-uid width.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 req_v_i  in  1  decode presents a load/store.
REQ-007 req_we_i  in  1  1=store, 0=load.
REQ-008 req_size_i  in  2  0=byte, 1=half, 2=word; 3 SHALL be treated as word.
REQ-009 req_signed_i  in  1  load sign-extends.
REQ-010 req_base_i / req_imm_i / req_wdata_i  in  32 each  rs1, immediate, rs2.
REQ-011 req_rd_i  in  RIDX_W; req_uid_i  in  UID_W  destination, uid.
REQ-012 lsq_full_o / lsq_empty_o  out  1  occupancy flags; full stalls decode.
REQ-013 data_req_o, data_we_o  out  1; data_addr_o, data_wdata_o  out  32; data_wstrb_o  out  4  memory request.
REQ-014 data_gnt_i, data_ready_i  in  1; data_rdata_i  in  32  grant, in-order response.
REQ-015 rf_we_o  out  1; rf_dst_o  out  RIDX_W; rf_wdata_o  out  32; uid_o  out  UID_W  writeback.
REQ-016 misalign_o  out  1; misalign_uid_o  out  UID_W; misalign_addr_o  out  32  exception.
REQ-017 flush_i  in  1  pipeline flush.

Function
REQ-018 addr = req_base_i + req_imm_i, modulo 2^32.
REQ-019 Pointers wr/iss/rd of log2(DEPTH)+1 bits; occupancy = wr-rd; full when occupancy==DEPTH, empty when 0; flags decoded combinationally from registered pointers.
REQ-020 Accept = req_v_i & ~lsq_full_o & ~flush_i & aligned; accepted op written at wr, wr+1; req_v_i while full or during flush dropped, no state change.
REQ-021 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): not enqueued, no memory request; next cycle misalign_o=1 for one cycle with uid, addr.
REQ-022 Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged; wstrb: byte 4'b0001<<addr[1:0], half addr[1]?1100:0011, word 1111; data_wstrb_o=0 for loads.
REQ-023 Issue candidate: entry at iss if iss!=wr, else the op accepted this cycle (bypass); issue when candidate exists and (~data_req_o | data_gnt_i); request registered, iss+1.
REQ-024 Latency: op accepted at cycle N into empty, idle LSU -> data_req_o=1 at N+1.
REQ-025 While data_req_o=1 and data_gnt_i=0, data_req_o/we/addr/wdata/wstrb SHALL hold stable; gnt with no new candidate drops data_req_o next cycle.
REQ-026 Back-to-back: gnt and new candidate in same cycle keep data_req_o=1 with next op's fields.
REQ-027 data_ready_i retires entry at rd (rd+1); ignored when rd==iss.
REQ-028 Load retire: next cycle rf_we_o=1 one cycle, rf_dst_o/uid_o from entry, rf_wdata_o = lane addr[1:0] (byte) or addr[1] (half) of data_rdata_i, sign- or zero-extended per req_signed_i; store retire: rf_we_o=0.
REQ-029 Accept and retire same cycle permitted; full is registered, so no accept at full even if retiring.
REQ-030 flush_i: wr <= iss (unissued entries discarded; a held, ungranted request counts as issued); issued loads marked killed and retire with rf_we_o=0; issued stores complete normally.
REQ-031 Pointer wrap modulo 2^(log2(DEPTH)+1); no entry lost or duplicated at wrap.

Reset
REQ-032 resetn low: pointers=0, data_req_o=0, data_we_o=0, rf_we_o=0, misalign_o=0, kill bits=0; lsq_empty_o=1, lsq_full_o=0; other outputs 0.
REQ-033 Reset mid-transaction aborts all entries; data_ready_i after reset ignored (rd==iss).

Verification
REQ-034 Load word base 0x100, imm 4, gnt same cycle, ready next, rdata 0xDEADBEEF -> data_addr_o=0x104 at N+1, rf_we_o=1 with rf_wdata_o=0xDEADBEEF at N+3.
REQ-035 lb signed addr 0x203, rdata 0x80000000 -> rf_wdata_o=0xFFFFFF80; lbu same -> 0x00000080; sh addr 0x202 data 0x1234 -> wdata 0x12341234, wstrb 1100.
REQ-036 DEPTH=8, gnt low, 8 stores -> lsq_full_o=1, 9th dropped; raise gnt/ready -> 8 ordered requests, empty again, pointers wrapped; repeat 3 rounds.
REQ-037 lw addr 0x102 -> misalign_o pulse with addr 0x102, no data_req_o, queue unchanged.
REQ-038 Two loads issued, two queued, flush_i -> queued never requested; two responses give rf_we_o=0; lsq_empty_o=1 after.
REQ-039 resetn low while data_req_o=1 -> all outputs reset that cycle; subsequent data_ready_i produces no rf_we_o.

Source files
------------

// File: rtl/n2_lsu_pq.sv
// In-order load/store queue: enqueues decoded memory ops, issues them to a
// valid/grant data port, and writes load results back as responses return.
module n2_lsu_pq #(
    parameter int DEPTH  = 8,
    parameter int RIDX_W = 5,
    parameter int UID_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_v_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [31:0]       req_base_i,
    input  logic [31:0]       req_imm_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [RIDX_W-1:0] req_rd_i,
    input  logic [UID_W-1:0]  req_uid_i,
    output logic              lsq_full_o,
    output logic              lsq_empty_o,
    output logic              data_req_o,
    output logic              data_we_o,
    output logic [31:0]       data_addr_o,
    output logic [31:0]       data_wdata_o,
    output logic [3:0]        data_wstrb_o,
    input  logic              data_gnt_i,
    input  logic              data_ready_i,
    input  logic [31:0]       data_rdata_i,
    output logic              rf_we_o,
    output logic [RIDX_W-1:0] rf_dst_o,
    output logic [31:0]       rf_wdata_o,
    output logic [UID_W-1:0]  uid_o,
    output logic              misalign_o,
    output logic [UID_W-1:0]  misalign_uid_o,
    output logic [31:0]       misalign_addr_o,
    input  logic              flush_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              sgn;
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic [3:0]        wstrb;
        logic [RIDX_W-1:0] rd;
        logic [UID_W-1:0]  uid;
        logic              kill;
    } ent_t;

    ent_t ent_q [DEPTH];
    ent_t ent_d [DEPTH];

    logic [PW-1:0] wr_q, wr_d, iss_q, iss_d, rd_q, rd_d;

    logic              data_req_q, data_req_d;
    logic              data_we_q, data_we_d;
    logic [31:0]       data_addr_q, data_addr_d;
    logic [31:0]       data_wdata_q, data_wdata_d;
    logic [3:0]        data_wstrb_q, data_wstrb_d;
    logic              rf_we_q, rf_we_d;
    logic [RIDX_W-1:0] rf_dst_q, rf_dst_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;
    logic [UID_W-1:0]  uid_q, uid_d;
    logic              mis_q, mis_d;
    logic [UID_W-1:0]  mis_uid_q, mis_uid_d;
    logic [31:0]       mis_addr_q, mis_addr_d;

    logic [31:0] addr;
    logic        is_byte, is_half, is_word, mis, take, accept;
    logic        full, empty;
    ent_t        new_ent;
    logic [31:0] new_wdata;
    logic [3:0]  new_wstrb;

    logic [AW-1:0] iidx, ridx, off;
    logic          pend, cand_v, issue, ret;
    logic [PW-1:0] issued_cnt;
    logic [7:0]    b8;
    logic [15:0]   h16;
    logic [31:0]   ldata;

    assign full        = (wr_q - rd_q) == PW'(DEPTH);
    assign empty       = wr_q == rd_q;
    assign lsq_full_o  = full;
    assign lsq_empty_o = empty;

    assign data_req_o      = data_req_q;
    assign data_we_o       = data_we_q;
    assign data_addr_o     = data_addr_q;
    assign data_wdata_o    = data_wdata_q;
    assign data_wstrb_o    = data_wstrb_q;
    assign rf_we_o         = rf_we_q;
    assign rf_dst_o        = rf_dst_q;
    assign rf_wdata_o      = rf_wdata_q;
    assign uid_o           = uid_q;
    assign misalign_o      = mis_q;
    assign misalign_uid_o  = mis_uid_q;
    assign misalign_addr_o = mis_addr_q;

    always_comb begin
        addr    = req_base_i + req_imm_i;
        is_word = req_size_i[1];
        is_half = req_size_i == 2'd1;
        is_byte = req_size_i == 2'd0;
        mis     = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'd0));
        take    = req_v_i & ~full & ~flush_i;
        accept  = take & ~mis;

        new_wdata = 32'd0;
        new_wstrb = 4'd0;
        unique case (1'b1)
            is_byte: begin
                new_wdata = {4{req_wdata_i[7:0]}};
                new_wstrb = 4'b0001 << addr[1:0];
            end
            is_half: begin
                new_wdata = {2{req_wdata_i[15:0]}};
                new_wstrb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                new_wdata = req_wdata_i;
                new_wstrb = 4'b1111;
            end
        endcase
        // Loads never drive write data or byte strobes.
        if (!req_we_i) begin
            new_wdata = 32'd0;
            new_wstrb = 4'd0;
        end

        new_ent.we    = req_we_i;
        new_ent.size  = is_word ? 2'd2 : req_size_i;
        new_ent.sgn   = req_signed_i;
        new_ent.addr  = addr;
        new_ent.wdata = new_wdata;
        new_ent.wstrb = new_wstrb;
        new_ent.rd    = req_rd_i;
        new_ent.uid   = req_uid_i;
        new_ent.kill  = 1'b0;
    end

    always_comb begin
        iidx   = iss_q[AW-1:0];
        pend   = iss_q != wr_q;
        cand_v = pend | accept;
        issue  = cand_v & (~data_req_q | data_gnt_i) & ~flush_i;

        data_req_d   = data_req_q;
        data_we_d    = data_we_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        data_wstrb_d = data_wstrb_q;
        if (issue) begin
            data_req_d   = 1'b1;
            data_we_d    = pend ? ent_q[iidx].we    : new_ent.we;
            data_addr_d  = pend ? ent_q[iidx].addr  : new_ent.addr;
            data_wdata_d = pend ? ent_q[iidx].wdata : new_ent.wdata;
            data_wstrb_d = pend ? ent_q[iidx].wstrb : new_ent.wstrb;
        end else if (data_req_q && data_gnt_i) begin
            data_req_d = 1'b0;
        end

        mis_d      = take & mis;
        mis_uid_d  = mis_uid_q;
        mis_addr_d = mis_addr_q;
        if (take && mis) begin
            mis_uid_d  = req_uid_i;
            mis_addr_d = addr;
        end
    end

    always_comb begin
        ridx = rd_q[AW-1:0];
        ret  = data_ready_i & (rd_q != iss_q);

        b8 = 8'd0;
        unique case (ent_q[ridx].addr[1:0])
            2'd0: b8 = data_rdata_i[7:0];
            2'd1: b8 = data_rdata_i[15:8];
            2'd2: b8 = data_rdata_i[23:16];
            2'd3: b8 = data_rdata_i[31:24];
        endcase
        h16 = ent_q[ridx].addr[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

        unique case (ent_q[ridx].size)
            2'd0:    ldata = {{24{ent_q[ridx].sgn & b8[7]}}, b8};
            2'd1:    ldata = {{16{ent_q[ridx].sgn & h16[15]}}, h16};
            default: ldata = data_rdata_i;
        endcase

        rf_we_d    = ret & ~ent_q[ridx].we & ~ent_q[ridx].kill;
        rf_dst_d   = rf_dst_q;
        rf_wdata_d = rf_wdata_q;
        uid_d      = uid_q;
        if (ret) begin
            rf_dst_d   = ent_q[ridx].rd;
            rf_wdata_d = ldata;
            uid_d      = ent_q[ridx].uid;
        end
    end

    always_comb begin
        issued_cnt = iss_q - rd_q;
        off        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            off      = AW'(i) - ridx;
            // Issued-but-unretired loads lose their writeback on flush.
            if (flush_i && ({1'b0, off} < issued_cnt))
                ent_d[i].kill = 1'b1;
        end
        if (accept)
            ent_d[wr_q[AW-1:0]] = new_ent;

        wr_d  = flush_i ? iss_q : wr_q + PW'(accept);
        iss_d = iss_q + PW'(issue);
        rd_d  = rd_q + PW'(ret);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
            wr_q         <= '0;
            iss_q        <= '0;
            rd_q         <= '0;
            data_req_q   <= 1'b0;
            data_we_q    <= 1'b0;
            data_addr_q  <= 32'd0;
            data_wdata_q <= 32'd0;
            data_wstrb_q <= 4'd0;
            rf_we_q      <= 1'b0;
            rf_dst_q     <= '0;
            rf_wdata_q   <= 32'd0;
            uid_q        <= '0;
            mis_q        <= 1'b0;
            mis_uid_q    <= '0;
            mis_addr_q   <= 32'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= ent_d[i];
            wr_q         <= wr_d;
            iss_q        <= iss_d;
            rd_q         <= rd_d;
            data_req_q   <= data_req_d;
            data_we_q    <= data_we_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            data_wstrb_q <= data_wstrb_d;
            rf_we_q      <= rf_we_d;
            rf_dst_q     <= rf_dst_d;
            rf_wdata_q   <= rf_wdata_d;
            uid_q        <= uid_d;
            mis_q        <= mis_d;
            mis_uid_q    <= mis_uid_d;
            mis_addr_q   <= mis_addr_d;
        end
    end

endmodule

// File: tb/tb_n2_lsu_pq.sv
// Directed bench for n2_lsu_pq: single-op vector table plus
// multi-cycle sequences for fill/drain, flush, misalign and reset.
module tb_n2_lsu_pq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_v_i, req_we_i, req_signed_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_base_i, req_imm_i, req_wdata_i;
    logic [4:0]  req_rd_i;
    logic [7:0]  req_uid_i;
    logic        lsq_full_o, lsq_empty_o;
    logic        data_req_o, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_wstrb_o;
    logic        data_gnt_i, data_ready_i;
    logic [31:0] data_rdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_dst_o;
    logic [31:0] rf_wdata_o;
    logic [7:0]  uid_o;
    logic        misalign_o;
    logic [7:0]  misalign_uid_o;
    logic [31:0] misalign_addr_o;
    logic        flush_i;

    n2_lsu_pq #(.DEPTH(8), .RIDX_W(5), .UID_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .req_v_i(req_v_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_signed_i(req_signed_i), .req_base_i(req_base_i),
        .req_imm_i(req_imm_i), .req_wdata_i(req_wdata_i),
        .req_rd_i(req_rd_i), .req_uid_i(req_uid_i),
        .lsq_full_o(lsq_full_o), .lsq_empty_o(lsq_empty_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_wstrb_o(data_wstrb_o), .data_gnt_i(data_gnt_i),
        .data_ready_i(data_ready_i), .data_rdata_i(data_rdata_i),
        .rf_we_o(rf_we_o), .rf_dst_o(rf_dst_o), .rf_wdata_o(rf_wdata_o),
        .uid_o(uid_o), .misalign_o(misalign_o),
        .misalign_uid_o(misalign_uid_o), .misalign_addr_o(misalign_addr_o),
        .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        logic [31:0] e_rf;
    } vec_t;

    vec_t v [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [1:0] sz,
                             input logic sg, input logic [31:0] base,
                             input logic [31:0] imm, input logic [31:0] wd,
                             input logic [4:0] rd, input logic [7:0] uid);
        req_v_i      = 1'b1;
        req_we_i     = we;
        req_size_i   = sz;
        req_signed_i = sg;
        req_base_i   = base;
        req_imm_i    = imm;
        req_wdata_i  = wd;
        req_rd_i     = rd;
        req_uid_i    = uid;
    endtask

    int ngr;
    int nreq;
    logic pend;
    logic [31:0] exp_a;

    initial begin
        v[0] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h4, 32'h0, 32'hDEADBEEF,
                 32'h104, 32'h0, 4'h0, 32'hDEADBEEF};
        v[1] = '{1'b0, 2'd0, 1'b1, 32'h200, 32'h3, 32'h0, 32'h80000000,
                 32'h203, 32'h0, 4'h0, 32'hFFFFFF80};
        v[2] = '{1'b0, 2'd0, 1'b0, 32'h200, 32'h3, 32'h0, 32'h80000000,
                 32'h203, 32'h0, 4'h0, 32'h00000080};
        v[3] = '{1'b1, 2'd1, 1'b0, 32'h200, 32'h2, 32'h1234, 32'h0,
                 32'h202, 32'h12341234, 4'b1100, 32'h0};
        v[4] = '{1'b1, 2'd0, 1'b0, 32'h301, 32'h0, 32'h55AB, 32'h0,
                 32'h301, 32'hABABABAB, 4'b0010, 32'h0};
        v[5] = '{1'b1, 2'd2, 1'b0, 32'h400, 32'hFFFFFFFC, 32'h11223344,
                 32'h0, 32'h3FC, 32'h11223344, 4'b1111, 32'h0};
        v[6] = '{1'b0, 2'd1, 1'b1, 32'h500, 32'h2, 32'h0, 32'h80011234,
                 32'h502, 32'h0, 4'h0, 32'hFFFF8001};
        v[7] = '{1'b0, 2'd1, 1'b0, 32'h500, 32'h0, 32'h0, 32'h8001F234,
                 32'h500, 32'h0, 4'h0, 32'h0000F234};
        v[8] = '{1'b0, 2'd3, 1'b0, 32'h600, 32'h0, 32'h0, 32'h12345678,
                 32'h600, 32'h0, 4'h0, 32'h12345678};
        v[9] = '{1'b0, 2'd0, 1'b0, 32'h701, 32'h0, 32'h0, 32'h0000A500,
                 32'h701, 32'h0, 4'h0, 32'h000000A5};

        resetn = 1'b0;
        req_v_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
        req_signed_i = 1'b0; req_base_i = 32'd0; req_imm_i = 32'd0;
        req_wdata_i = 32'd0; req_rd_i = 5'd0; req_uid_i = 8'd0;
        data_gnt_i = 1'b0; data_ready_i = 1'b0; data_rdata_i = 32'd0;
        flush_i = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(data_req_o), 32'd0);
        chk("rst_rfwe", 32'(rf_we_o), 32'd0);
        chk("rst_mis", 32'(misalign_o), 32'd0);
        chk("rst_empty", 32'(lsq_empty_o), 32'd1);
        chk("rst_full", 32'(lsq_full_o), 32'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            drive_req(v[i].we, v[i].size, v[i].sgn, v[i].base, v[i].imm,
                      v[i].wdata, 5'(i + 1), 8'(8'h40 + i));
            tick();
            req_v_i = 1'b0;
            chk($sformatf("v%0d_req", i), 32'(data_req_o), 32'd1);
            chk($sformatf("v%0d_we", i), 32'(data_we_o), 32'(v[i].we));
            chk($sformatf("v%0d_addr", i), data_addr_o, v[i].e_addr);
            chk($sformatf("v%0d_wdata", i), data_wdata_o, v[i].e_wdata);
            chk($sformatf("v%0d_strb", i), 32'(data_wstrb_o),
                32'(v[i].e_strb));
            data_gnt_i = 1'b1;
            tick();
            data_gnt_i = 1'b0;
            chk($sformatf("v%0d_drop", i), 32'(data_req_o), 32'd0);
            data_ready_i = 1'b1;
            data_rdata_i = v[i].rdata;
            tick();
            data_ready_i = 1'b0;
            chk($sformatf("v%0d_rfwe", i), 32'(rf_we_o), 32'(!v[i].we));
            if (!v[i].we) begin
                chk($sformatf("v%0d_rfdata", i), rf_wdata_o, v[i].e_rf);
                chk($sformatf("v%0d_dst", i), 32'(rf_dst_o), 32'(i + 1));
                chk($sformatf("v%0d_uid", i), 32'(uid_o), 32'(8'h40 + i));
            end
            chk($sformatf("v%0d_empty", i), 32'(lsq_empty_o), 32'd1);
        end

        drive_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h2, 32'h0, 5'd3, 8'h77);
        tick();
        req_v_i = 1'b0;
        chk("mis_pulse", 32'(misalign_o), 32'd1);
        chk("mis_addr", misalign_addr_o, 32'h102);
        chk("mis_uid", 32'(misalign_uid_o), 32'h77);
        chk("mis_noreq", 32'(data_req_o), 32'd0);
        chk("mis_empty", 32'(lsq_empty_o), 32'd1);
        tick();
        chk("mis_end", 32'(misalign_o), 32'd0);
        chk("mis_noreq2", 32'(data_req_o), 32'd0);

        for (int r = 0; r < 3; r++) begin
            data_gnt_i = 1'b0;
            data_ready_i = 1'b0;
            for (int k = 0; k < 8; k++) begin
                drive_req(1'b1, 2'd2, 1'b0, 32'h1000 * (r + 1) + 32'(4 * k),
                          32'h0, 32'(k), 5'd0, 8'(k));
                tick();
            end
            chk($sformatf("r%0d_full", r), 32'(lsq_full_o), 32'd1);
            drive_req(1'b1, 2'd2, 1'b0, 32'hDEAD0, 32'h0, 32'h0, 5'd0, 8'hFF);
            tick();
            req_v_i = 1'b0;
            chk($sformatf("r%0d_full9", r), 32'(lsq_full_o), 32'd1);
            data_gnt_i = 1'b1;
            pend = 1'b0;
            ngr = 0;
            for (int c = 0; c < 30; c++) begin
                if (data_req_o) begin
                    exp_a = (ngr < 8) ? 32'h1000 * (r + 1) + 32'(4 * ngr)
                                      : 32'hFFFFFFFF;
                    chk($sformatf("r%0d_ord%0d", r, ngr), data_addr_o, exp_a);
                    ngr++;
                end
                data_ready_i = pend;
                pend = data_req_o;
                tick();
            end
            data_gnt_i = 1'b0;
            data_ready_i = 1'b0;
            chk($sformatf("r%0d_ngrant", r), 32'(ngr), 32'd8);
            chk($sformatf("r%0d_empty", r), 32'(lsq_empty_o), 32'd1);
            chk($sformatf("r%0d_nfull", r), 32'(lsq_full_o), 32'd0);
        end

        drive_req(1'b0, 2'd2, 1'b0, 32'hA00, 32'h0, 32'h0, 5'd1, 8'h01);
        tick();
        chk("fl_a", data_addr_o, 32'hA00);
        drive_req(1'b0, 2'd2, 1'b0, 32'hA04, 32'h0, 32'h0, 5'd2, 8'h02);
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        chk("fl_b2b", data_addr_o, 32'hA04);
        chk("fl_b2b_req", 32'(data_req_o), 32'd1);
        drive_req(1'b0, 2'd2, 1'b0, 32'hA08, 32'h0, 32'h0, 5'd3, 8'h03);
        tick();
        drive_req(1'b0, 2'd2, 1'b0, 32'hA0C, 32'h0, 32'h0, 5'd4, 8'h04);
        tick();
        chk("fl_hold", data_addr_o, 32'hA04);
        req_v_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_held", 32'(data_req_o), 32'd1);
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        nreq = 0;
        for (int c = 0; c < 6; c++) begin
            if (data_req_o) nreq++;
            tick();
        end
        chk("fl_noreq", 32'(nreq), 32'd0);
        chk("fl_nempty", 32'(lsq_empty_o), 32'd0);
        data_ready_i = 1'b1;
        data_rdata_i = 32'h12345678;
        tick();
        chk("fl_kill1", 32'(rf_we_o), 32'd0);
        tick();
        data_ready_i = 1'b0;
        chk("fl_kill2", 32'(rf_we_o), 32'd0);
        chk("fl_empty", 32'(lsq_empty_o), 32'd1);

        drive_req(1'b0, 2'd2, 1'b0, 32'h800, 32'h0, 32'h0, 5'd5, 8'h05);
        tick();
        req_v_i = 1'b0;
        chk("rs_req", 32'(data_req_o), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rs_req0", 32'(data_req_o), 32'd0);
        chk("rs_addr0", data_addr_o, 32'd0);
        chk("rs_empty", 32'(lsq_empty_o), 32'd1);
        tick();
        resetn = 1'b1;
        data_ready_i = 1'b1;
        tick();
        chk("rs_rfwe1", 32'(rf_we_o), 32'd0);
        tick();
        data_ready_i = 1'b0;
        chk("rs_rfwe2", 32'(rf_we_o), 32'd0);
        chk("rs_noreq", 32'(data_req_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
